// File: rtl/exec_complete_arbiter.sv
// ---------------------------------------------------------------------------
// exec_complete_arbiter
//
// Purpose:
//   Collects finished results from NUM_UNITS execution units (ALU, multiplier,
//   divider, ...). Each cycle it grants at most one of them, using round-robin
//   fairness, and registers the winner into a single-entry CDB slot. The slot
//   drains to the ROB under a ready handshake.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   unitValid_i    per-unit result valid (held by the unit until granted)
//   unitTag_i      packed ROB tags, unit k at [k*ROBsizeLog +: ROBsizeLog]
//   unitVal_i      packed 64-bit results
//   unitCommands_i packed 10-bit commands
//   unitFlags_i    packed 4-bit flags
//   canGo_o        per-unit grant (one-hot or zero); transfer on valid&canGo
//   flush_i        mispredict flush: kills the slot and suppresses grants
//   cdbReady_i     ROB accepts the CDB entry this cycle
//   cdbValid_o     CDB slot holds a result
//   cdbTag_o       tag of the CDB entry
//   cdbVal_o       result value
//   cdbCommands_o  commands
//   cdbFlags_o     flags
//   grantCount_o   total grants since reset (wraps)
// ---------------------------------------------------------------------------
module exec_complete_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_UNITS-1:0]            unitValid_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
  input  logic [NUM_UNITS*64-1:0]         unitVal_i,
  input  logic [NUM_UNITS*10-1:0]         unitCommands_i,
  input  logic [NUM_UNITS*4-1:0]          unitFlags_i,
  output logic [NUM_UNITS-1:0]            canGo_o,
  input  logic                            flush_i,
  input  logic                            cdbReady_i,
  output logic                            cdbValid_o,
  output logic [ROBsizeLog-1:0]           cdbTag_o,
  output logic [63:0]                     cdbVal_o,
  output logic [9:0]                      cdbCommands_o,
  output logic [3:0]                      cdbFlags_o,
  output logic [31:0]                     grantCount_o
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Unpacked views of the per-unit payload buses
  logic [ROBsizeLog-1:0] tag_arr_s [NUM_UNITS];
  logic [63:0]           val_arr_s [NUM_UNITS];
  logic [9:0]            cmd_arr_s [NUM_UNITS];
  logic [3:0]            flg_arr_s [NUM_UNITS];

  // Slot and arbitration state
  logic                  cdb_valid_q, cdb_valid_d;
  logic [ROBsizeLog-1:0] cdb_tag_q,   cdb_tag_d;
  logic [63:0]           cdb_val_q,   cdb_val_d;
  logic [9:0]            cdb_cmd_q,   cdb_cmd_d;
  logic [3:0]            cdb_flg_q,   cdb_flg_d;
  logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [31:0]           grant_cnt_q, grant_cnt_d;

  // Arbitration results
  logic                  can_grant_s;
  logic                  grant_any_s;
  logic [NUM_UNITS-1:0]  grant_s;
  logic [PTR_W-1:0]      winner_s;
  logic [PTR_W-1:0]      idx_s;

  // Split the packed payload buses into per-unit arrays
  always_comb begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      tag_arr_s[k] = unitTag_i[k*ROBsizeLog +: ROBsizeLog];
      val_arr_s[k] = unitVal_i[k*64 +: 64];
      cmd_arr_s[k] = unitCommands_i[k*10 +: 10];
      flg_arr_s[k] = unitFlags_i[k*4 +: 4];
    end
  end

  // Round-robin scan starting at rr_ptr_q; the first valid unit wins
  always_comb begin
    can_grant_s = (~cdb_valid_q | cdbReady_i) & ~flush_i & ~reset_i;
    grant_s     = '0;
    grant_any_s = 1'b0;
    winner_s    = '0;
    idx_s       = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx_s = PTR_W'((int'(rr_ptr_q) + i) % NUM_UNITS);
      if (can_grant_s && !grant_any_s && unitValid_i[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_any_s    = 1'b1;
        winner_s       = idx_s;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  assign canGo_o = grant_s;

  // Next-state for the CDB slot, pointer and grant counter
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_val_d   = cdb_val_q;
    cdb_cmd_d   = cdb_cmd_q;
    cdb_flg_d   = cdb_flg_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    if (flush_i) begin
      // Grants are already suppressed; only the slot is killed
      cdb_valid_d = 1'b0;
    end else if (grant_any_s) begin
      // Covers both the empty-slot load and the drain-and-replace case
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_arr_s[winner_s];
      cdb_val_d   = val_arr_s[winner_s];
      cdb_cmd_d   = cmd_arr_s[winner_s];
      cdb_flg_d   = flg_arr_s[winner_s];
      grant_cnt_d = grant_cnt_q + 32'd1;
      if (winner_s == PTR_W'(NUM_UNITS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner_s + PTR_W'(1);
      end
    end else if (cdbReady_i) begin
      // Plain drain: payload registers keep their stale contents
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= 64'd0;
      cdb_cmd_q   <= 10'd0;
      cdb_flg_q   <= 4'd0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= 32'd0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_val_q   <= cdb_val_d;
      cdb_cmd_q   <= cdb_cmd_d;
      cdb_flg_q   <= cdb_flg_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign cdbValid_o    = cdb_valid_q;
  assign cdbTag_o      = cdb_tag_q;
  assign cdbVal_o      = cdb_val_q;
  assign cdbCommands_o = cdb_cmd_q;
  assign cdbFlags_o    = cdb_flg_q;
  assign grantCount_o  = grant_cnt_q;

endmodule

// File: tb/tb_exec_complete_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exec_complete_arbiter
//
// Self-checking bench for exec_complete_arbiter. A behavioural model tracks
// the CDB slot, the round-robin pointer and the grant count. The model picks
// the valid unit at the smallest forward distance from the pointer. A compare
// process checks every output against the model on each falling edge. The
// directed sequence also checks hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_exec_complete_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;

  logic              clk;
  logic              reset;
  logic [N-1:0]      valid;
  logic              flush;
  logic              ready;
  logic [N*TW-1:0]   tag_bus;
  logic [N*64-1:0]   val_bus;
  logic [N*10-1:0]   cmd_bus;
  logic [N*4-1:0]    flg_bus;
  logic [N-1:0]      can_go;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [63:0]       cdb_val;
  logic [9:0]        cdb_cmd;
  logic [3:0]        cdb_flg;
  logic [31:0]       grant_cnt;

  logic [TW-1:0]     u_tag [N];
  logic [63:0]       u_val [N];
  logic [9:0]        u_cmd [N];
  logic [3:0]        u_flg [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Model state
  bit           m_valid;
  logic [TW-1:0] m_tag;
  logic [63:0]  m_val;
  logic [9:0]   m_cmd;
  logic [3:0]   m_flg;
  int           m_ptr;
  logic [31:0]  m_cnt;

  exec_complete_arbiter #(.NUM_UNITS(N), .ROBsize(32)) dut (
    .clk_i(clk), .reset_i(reset), .unitValid_i(valid), .unitTag_i(tag_bus),
    .unitVal_i(val_bus), .unitCommands_i(cmd_bus), .unitFlags_i(flg_bus),
    .canGo_o(can_go), .flush_i(flush), .cdbReady_i(ready),
    .cdbValid_o(cdb_valid), .cdbTag_o(cdb_tag), .cdbVal_o(cdb_val),
    .cdbCommands_o(cdb_cmd), .cdbFlags_o(cdb_flg), .grantCount_o(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      tag_bus[k*TW +: TW] = u_tag[k];
      val_bus[k*64 +: 64] = u_val[k];
      cmd_bus[k*10 +: 10] = u_cmd[k];
      flg_bus[k*4 +: 4]   = u_flg[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner chosen by the rules: the valid unit nearest the pointer going upward
  function automatic int model_grant();
    int best, bestd, d;
    best = -1;
    bestd = N;
    if (reset || flush || (m_valid && !ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (valid[k]) begin
        d = (k - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  // Model update on each active edge
  always @(posedge clk) begin
    int g;
    g = model_grant();
    if (reset) begin
      m_valid = 1'b0; m_tag = '0; m_val = '0; m_cmd = '0; m_flg = '0;
      m_ptr = 0; m_cnt = '0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_tag = u_tag[g]; m_val = u_val[g]; m_cmd = u_cmd[g]; m_flg = u_flg[g];
      m_ptr = (g + 1) % N;
      m_cnt = m_cnt + 32'd1;
    end else if (ready) begin
      m_valid = 1'b0;
    end
  end

  // Compare process: every output against the model, away from the edge
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_go;
    if (cmp_en) begin
      g = model_grant();
      exp_go = (g >= 0) ? (N'(1) << g) : '0;
      chk("canGo", 64'(can_go), 64'(exp_go));
      chk("cdbValid", 64'(cdb_valid), 64'(m_valid));
      chk("cdbTag", 64'(cdb_tag), 64'(m_tag));
      chk("cdbVal", cdb_val, m_val);
      chk("cdbCmd", 64'(cdb_cmd), 64'(m_cmd));
      chk("cdbFlags", 64'(cdb_flg), 64'(m_flg));
      chk("grantCount", 64'(grant_cnt), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ready = 1'b1; valid = '0;
    u_tag[0] = 6'd7; u_val[0] = 64'hAAAA_0000_0000_0001; u_cmd[0] = 10'd1;  u_flg[0] = 4'd1;
    u_tag[1] = 6'd2; u_val[1] = 64'hBBBB_0000_0000_0002; u_cmd[1] = 10'd2;  u_flg[1] = 4'd2;
    u_tag[2] = 6'd5; u_val[2] = 64'h0000_0000_0000_1234; u_cmd[2] = 10'd10; u_flg[2] = 4'd3;
    u_tag[3] = 6'd4; u_val[3] = 64'hDDDD_0000_0000_0004; u_cmd[3] = 10'd4;  u_flg[3] = 4'd4;
    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single grant from unit 2 after reset
    valid = 4'b0100;
    #2 chk("t1_canGo", 64'(can_go), 64'(4'b0100));
    tick();
    valid = 4'b0000;
    #2;
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag", 64'(cdb_tag), 64'd5);
    chk("t1_val", cdb_val, 64'h1234);
    chk("t1_cmd", 64'(cdb_cmd), 64'd10);
    chk("t1_cnt", 64'(grant_cnt), 64'd1);
    chk("t1_ptr", 64'(m_ptr), 64'd3);

    // All four units valid continuously: 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #2 chk("t2_canGo", 64'(can_go), 64'(4'b0001 << (i % 4)));
      tick();
    end
    #2;
    chk("t2_cnt", 64'(grant_cnt), 64'd5);
    chk("t2_tag", 64'(cdb_tag), 64'd7);
    chk("t2_valid", 64'(cdb_valid), 64'd1);

    // Stall with units 1 and 3 waiting
    valid = 4'b1010;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t3_canGo", 64'(can_go), 64'd0);
      chk("t3_tag", 64'(cdb_tag), 64'd7);
      tick();
    end
    ready = 1'b1;
    #2 chk("t3_release", 64'(can_go), 64'(4'b0010));
    tick();
    valid = 4'b1000;
    #2 chk("t3_newtag", 64'(cdb_tag), 64'd2);

    // Pointer wrap from unit 3 to unit 0
    valid = 4'b0100;
    #2 chk("t4_go2", 64'(can_go), 64'(4'b0100));
    tick();
    #0 chk("t4_ptr3", 64'(m_ptr), 64'd3);
    valid = 4'b1001;
    #2 chk("t4_go3", 64'(can_go), 64'(4'b1000));
    tick();
    #0 chk("t4_ptr0", 64'(m_ptr), 64'd0);
    valid = 4'b0001;
    #2 chk("t4_go0", 64'(can_go), 64'(4'b0001));
    tick();
    valid = 4'b0000;
    #2;
    chk("t4_ptr1", 64'(m_ptr), 64'd1);
    chk("t4_cnt", 64'(grant_cnt), 64'd9);
    chk("t4_valid", 64'(cdb_valid), 64'd1);

    // Reset mid-transfer with count 9
    reset = 1'b1;
    valid = 4'b1111;
    #2 chk("t6_canGo", 64'(can_go), 64'd0);
    tick();
    reset = 1'b0;
    valid = 4'b0000;
    #2;
    chk("t6_valid", 64'(cdb_valid), 64'd0);
    chk("t6_tag", 64'(cdb_tag), 64'd0);
    chk("t6_val", cdb_val, 64'd0);
    chk("t6_cnt", 64'(grant_cnt), 64'd0);

    // Flush with slot full and unit 0 waiting
    valid = 4'b0001;
    tick();
    ready = 1'b0;
    flush = 1'b1;
    #2 chk("t5_canGo", 64'(can_go), 64'd0);
    tick();
    flush = 1'b0;
    #2;
    chk("t5_valid", 64'(cdb_valid), 64'd0);
    chk("t5_regrant", 64'(can_go), 64'(4'b0001));
    tick();
    valid = 4'b0000;
    ready = 1'b1;
    #2;
    chk("t5_cnt", 64'(grant_cnt), 64'd2);
    chk("t5_tag", 64'(cdb_tag), 64'd7);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      valid = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < N; k++) begin
        u_tag[k] = TW'($urandom);
        u_val[k] = {$urandom, $urandom};
        u_cmd[k] = 10'($urandom);
        u_flg[k] = 4'($urandom);
      end
      tick();
    end
    valid = '0; flush = 1'b0; reset = 1'b0; ready = 1'b1;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_complete_arbiter.md
Name: exec_complete_arbiter

Overview:
- Consumer end of the execute-stage completion handshake (valid_o / canGo_i) driven by each issue/exec stage: ALU, multiplier, divider, etc.
- Collects finished results from NUM_UNITS execution units and grants one per cycle with round-robin fairness.
- Registers the winner into a single-entry common-data-bus (CDB) output slot, which drains to the ROB under a ready handshake.
- Sits between the execution units and the ROB/CDB broadcast.

Parameters:
- NUM_UNITS, 4, number of execution units arbitrated (≥2).
- ROBsize, 32, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- unitValid_i  in  NUM_UNITS  per-unit result valid (unit holds it high until granted).
- unitTag_i  in  NUM_UNITS*ROBsizeLog  packed tags; unit k at [k*ROBsizeLog +: ROBsizeLog].
- unitVal_i  in  NUM_UNITS*64  packed 64-bit results.
- unitCommands_i  in  NUM_UNITS*10  packed 10-bit commands.
- unitFlags_i  in  NUM_UNITS*4  packed 4-bit flags.
- canGo_o  out  NUM_UNITS  per-unit grant; transfer occurs on the edge where valid and canGo are both high.
- flush_i  in  1  pipeline flush (mispredict); kills the CDB slot and suppresses grants.
- cdbReady_i  in  1  ROB accepts the CDB entry this cycle.
- cdbValid_o  out  1  CDB slot holds a result.
- cdbTag_o  out  ROBsizeLog  tag of CDB entry.
- cdbVal_o  out  64  result value.
- cdbCommands_o  out  10  commands.
- cdbFlags_o  out  4  flags.
- grantCount_o  out  32  total grants since reset (wraps at 2^32).

Behaviour:
- Reset (sync, active-high): cdbValid_o=0, cdbTag_o=0, cdbVal_o=0, cdbCommands_o=0, cdbFlags_o=0, grantCount_o=0, rrPtr_r=0. canGo_o=0 during any reset cycle.
- Slot acceptance: canAccept = ~cdbValid_o | cdbReady_i. Back-to-back throughput of 1 result/cycle when cdbReady_i is held high.
- Grant (combinational):
  - When canAccept & ~flush_i & ~reset_i, scan units from rrPtr_r upward modulo NUM_UNITS.
  - First unit with unitValid_i set gets canGo_o[k]=1.
  - canGo_o is one-hot or zero, never asserted to a unit whose valid is low, and is combinationally dependent only on unitValid_i, rrPtr_r, cdbValid_o, cdbReady_i, flush_i, reset_i.
- On a grant edge:
  - CDB registers load unit k's tag/val/commands/flags.
  - cdbValid_o <= 1.
  - rrPtr_r <= (k+1) mod NUM_UNITS (wrap from NUM_UNITS-1 to 0).
  - grantCount_o increments.
- Latency: unit valid with slot free -> canGo same cycle -> cdbValid_o next cycle.
- Drain without a new grant: cdbValid_o & cdbReady_i -> cdbValid_o <= 0. Data registers hold their value (don't-care while invalid).
- Stall: cdbValid_o & ~cdbReady_i -> CDB holds all outputs stable, canGo_o=0, rrPtr_r unchanged.
- Simultaneous drain and grant (cdbReady_i=1, slot full, unit valid): new entry replaces the old one; cdbValid_o stays 1.
- flush_i:
  - Next cycle cdbValid_o=0 regardless of cdbReady_i.
  - canGo_o=0 that cycle; rrPtr_r and grantCount_o unchanged.
  - Units are not granted, so they retain their results; units are flushed by their own logic.
- No valid units: canGo_o=0, rrPtr_r unchanged.
- Reset mid-transfer: any pending CDB entry is discarded; the counter and pointer clear.
- No internal FSM beyond the slot-valid bit and round-robin pointer. Each unit's own FSM waits in its done state until canGo.

Test Plan:
- Reset, then unit 2 valid (tag=5, val=0x1234, cmd=10) with cdbReady_i=1 -> canGo_o=0100 the same cycle; next cycle cdbValid_o=1, cdbTag_o=5, cdbVal_o=0x1234; rrPtr_r=3; grantCount_o=1.
- All 4 units valid continuously, cdbReady_i=1 -> grants 0,1,2,3,0 on consecutive cycles; cdbValid_o held 1; grantCount_o=5 after 5 cycles.
- Slot full (tag=7), cdbReady_i=0 for 3 cycles with units 1 and 3 valid -> canGo_o=0 and CDB outputs stable; cdbReady_i=1 -> unit 1 granted the same cycle, cdbTag_o updated next cycle.
- rrPtr_r=3, units 0 and 3 valid -> unit 3 granted first, then unit 0 (wrap); rrPtr_r becomes 0 then 1.
- flush_i with slot full and unit 0 valid -> canGo_o=0; next cycle cdbValid_o=0; unit 0 granted the cycle after flush deasserts.
- Assert reset_i while cdbValid_o=1 and grantCount_o=9 -> next cycle all outputs 0, canGo_o=0 during reset.
